lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store initiator that drives the word-wide main memory port: address, data_in, read_write, data_out.
- Takes one RV32I load or store request at a time from the execute stage and maps it onto memory accesses.
- Loads (LB/LH/LW/LBU/LHU) get byte-lane extraction and sign or zero extension.
- SW is a single write. SB/SH are a read-modify-write, because the memory only writes whole words.

Parameters:
- MEM_BASE, 'h01000000, byte address of memory location 0.
- MEM_DEPTH_BYTES, 'h0100000, memory size. Valid aligned word addresses run from MEM_BASE to MEM_BASE+MEM_DEPTH_BYTES-4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request is accepted on a rising edge when req_valid && req_ready.
- req_write  in  1  0 = load, 1 = store.
- req_funct3  in  3  RV32I funct3 (load: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store: 0 SB, 1 SH, 2 SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result (0 for stores and errors); registered, holds until the next response.
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, or out of range.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory data_in.
- mem_data_out  in  32  from memory data_out; combinational read of mem_address.
- mem_read_write  out  1  0 = READ, 1 = WRITE; memory commits on the rising edge while 1.

Behaviour:
- States: IDLE, LOAD, RMW_READ, WRITE, RESP. Reset forces IDLE.
- Reset values: resp_valid=0, resp_err=0, resp_rdata=0, mem_read_write=0, mem_address=MEM_BASE, mem_data_in=0. Latched request registers reset to 0.
- The request is latched at the accept edge. A = latched addr with low two bits cleared. lane = addr[1:0].
- Error check at accept: any of the following goes to RESP with err=1 and performs no memory access.
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - illegal funct3;
  - A outside [MEM_BASE, MEM_BASE+MEM_DEPTH_BYTES-4].
- IDLE transitions on accept (no error):
  - load -> LOAD;
  - SW -> WRITE, with the merge register = wdata;
  - SB/SH -> RMW_READ.
- LOAD:
  - Drive mem_address=A, read_write=0.
  - At the edge, capture the extracted value from mem_data_out into resp_rdata and go to RESP.
  - Extraction: LB/LBU use byte lane; LH/LHU use half addr[1]; LW uses the whole word. LB/LH sign-extend; LBU/LHU zero-extend.
- RMW_READ:
  - Drive mem_address=A, read_write=0.
  - At the edge, the merge register = mem_data_out with the selected byte/half replaced by wdata[7:0]/[15:0]. Go to WRITE.
- WRITE:
  - Drive mem_address=A, mem_data_in=merge register, read_write=1 for exactly one cycle.
  - Memory commits at the edge; go to RESP.
- RESP:
  - resp_valid=1 for one cycle (a Moore output of the state).
  - Next edge -> IDLE.
- Outside LOAD/RMW_READ/WRITE: mem_address=MEM_BASE, read_write=0, mem_data_in=0.
- Latency from accept edge to resp_valid:
  - loads: 1 cycle in LOAD, so resp_valid is high in the 2nd cycle after accept;
  - SW: same;
  - SB/SH: 3rd cycle;
  - errors: 1st cycle.
- Throughput: one request in flight. req_ready=0 from the accept edge through RESP, and requests are not accepted in the RESP cycle. req_valid held high is accepted again in the cycle after RESP.
- Reset mid-operation: all state clears immediately, read_write drops asynchronously, no memory write after reset assertion, no response is emitted for the aborted request.

Test Plan:
- Preload word 0x80FF7F01 at 0x01000000, then issue:
  - LBU @0x01000002 -> resp_rdata 0x000000FF, err 0;
  - LB @0x01000003 -> 0xFFFFFF80;
  - LB @0x01000000 -> 0x00000001.
- Same word, issue:
  - LH @0x01000002 -> 0xFFFF80FF;
  - LHU @0x01000002 -> 0x000080FF;
  - LW @0x01000000 -> 0x80FF7F01.
  - resp_valid is high exactly in the 2nd cycle after each accept edge and low otherwise.
- SB @0x01000001 with wdata 0xAAAAAA55 -> exactly one read_write=1 cycle, resp_valid on the 3rd cycle. A following LW reads 0x80FF5501. Then SH @0x01000002 with 0x1234BEEF -> LW reads 0xBEEF5501.
- Error requests, each giving resp_valid with err=1 in the 1st cycle after accept, resp_rdata=0, no read_write pulse, memory unchanged:
  - SH @0x01000001;
  - LW @0x01000002;
  - LW @0x00FFFFFC;
  - load funct3=3.
- Hold req_valid high across two back-to-back LW requests -> req_ready low from accept through RESP, second accept on the edge after the RESP cycle, no request lost or duplicated.
- Assert reset while in WRITE, before the edge -> read_write falls immediately, memory word unchanged, no resp_valid. After release, req_ready=1 and a fresh LW returns the original data.

Source files
------------

// File: rtl/lsu_mem_port.sv
// RV32I load/store initiator for a word-wide memory port.
// Sub-word stores are done as read-modify-write.
module lsu_mem_port #(
  parameter logic [31:0] MEM_BASE        = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam logic [31:0] LAST =
    MEM_BASE + MEM_DEPTH_BYTES - 32'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW, S_WRITE, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        f3_ok;
  logic        mis;
  logic [31:0] req_a;
  logic [31:0] word_a;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == S_IDLE);
  assign req_a  = {req_addr[31:2], 2'b00};
  assign word_a = {addr_q[31:2], 2'b00};

  always_comb begin
    f3_ok = 1'b0;
    if (req_write) f3_ok = (req_funct3 < 3'd3);
    else begin
      unique case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok = 1'b1;
        default:                      f3_ok = 1'b0;
      endcase
    end
    mis = ((req_funct3[1:0] == 2'd1) && req_addr[0])
       || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    req_err = !f3_ok || mis
           || (req_a < MEM_BASE) || (req_a > LAST);
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_b   = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? mem_data_out[31:16]
                         : mem_data_out[15:0];
    load_val = mem_data_out;
    unique case (f3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_val = {24'd0, lane_b};
      3'd5:    load_val = {16'd0, lane_h};
      default: load_val = mem_data_out;
    endcase
    merged = mem_data_out;
    if (f3_q[1:0] == 2'd0)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                       state_d = S_RESP;
          else if (!req_write)               state_d = S_LOAD;
          else if (req_funct3[1:0] == 2'd2)  state_d = S_WRITE;
          else                               state_d = S_RMW;
        end
      end
      S_LOAD:  state_d = S_RESP;
      S_RMW:   state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == S_IDLE);
    resp_valid     = (state_q == S_RESP);
    mem_address    = MEM_BASE;
    mem_data_in    = 32'd0;
    mem_read_write = 1'b0;
    unique case (state_q)
      S_LOAD, S_RMW: mem_address = word_a;
      S_WRITE: begin
        mem_address    = word_a;
        mem_data_in    = merge_q;
        mem_read_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Response data/err only change on the edge entering RESP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 16'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            merge_q <= req_wdata;
            if (req_err) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          rdata_q <= load_val;
          err_q   <= 1'b0;
        end
        S_RMW:   merge_q <= merged;
        S_WRITE: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: vector table, random model check,
// back-to-back and reset-abort sequences.
module tb_lsu_mem_port;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] DEPTH = 32'h0010_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;

  lsu_mem_port #(.MEM_BASE(BASE), .MEM_DEPTH_BYTES(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_read_write(mem_read_write)
  );

  always #5 clock = ~clock;

  // 256-word memory window at BASE; outside reads return a marker
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;
  int          wcount = 0;
  logic        in_win;

  assign in_win = (mem_address[31:10] == BASE[31:10]);
  assign mem_data_out = in_win ? mem[mem_address[9:2]]
                               : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_read_write) begin
      wcount <= wcount + 1;
      if (in_win) mem[mem_address[9:2]] <= mem_data_in;
    end
  end

  logic [7:0] ref_bytes [1024];
  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = 8'(idx); pl_data = d;
    for (int k = 0; k < 4; k++)
      ref_bytes[idx*4+k] = d[8*k +: 8];
    @(posedge clock); @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Starts and ends on a negedge with the DUT idle
  task automatic run_req(input logic w, input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         output int first, output int nresp,
                         output logic err, output logic [31:0] rd,
                         output int nwr);
    int w0;
    int t;
    first = 0; nresp = 0; err = 1'b0; rd = 32'd0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 10) begin
      @(posedge clock); @(negedge clock); t++;
    end
    w0 = wcount;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (resp_valid) begin
        nresp++;
        if (first == 0) begin
          first = k; err = resp_err; rd = resp_rdata;
        end
      end
      @(posedge clock); @(negedge clock);
    end
    nwr = wcount - w0;
    if (t >= 10) first = -1;
  endtask

  function automatic logic mdl_err(input logic w,
                                   input logic [2:0] f3,
                                   input logic [31:0] a);
    logic ok;
    int n;
    logic [31:0] wa;
    ok = w ? (f3 <= 3'd2)
           : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    n  = 1 << f3[1:0];
    wa = a - (a % 4);
    return !ok || (a % n != 0) || wa < BASE
        || wa > BASE + DEPTH - 4;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int off;
    int n;
    logic [31:0] v;
    off = int'(a - BASE);
    n   = 1 << f3[1:0];
    v   = 0;
    for (int k = 0; k < n; k++)
      v = v + (32'(ref_bytes[off+k]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1])
      v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nwr;
  } vec_t;

  vec_t tv [19];

  int          first, nresp, nwr, w0, hits;
  logic        err;
  logic [31:0] rd;
  logic [5:0]  rdy_pat, rsp_pat;

  initial begin
    tv[0]  = '{0, 3'd4, 32'h0100_0002, 0, 2, 0, 32'h0000_00FF, 0};
    tv[1]  = '{0, 3'd0, 32'h0100_0003, 0, 2, 0, 32'hFFFF_FF80, 0};
    tv[2]  = '{0, 3'd0, 32'h0100_0000, 0, 2, 0, 32'h0000_0001, 0};
    tv[3]  = '{0, 3'd1, 32'h0100_0002, 0, 2, 0, 32'hFFFF_80FF, 0};
    tv[4]  = '{0, 3'd5, 32'h0100_0002, 0, 2, 0, 32'h0000_80FF, 0};
    tv[5]  = '{0, 3'd2, 32'h0100_0000, 0, 2, 0, 32'h80FF_7F01, 0};
    tv[6]  = '{1, 3'd0, 32'h0100_0001, 32'hAAAA_AA55,
               3, 0, 32'h0, 1};
    tv[7]  = '{0, 3'd2, 32'h0100_0000, 0, 2, 0, 32'h80FF_5501, 0};
    tv[8]  = '{1, 3'd1, 32'h0100_0002, 32'h1234_BEEF,
               3, 0, 32'h0, 1};
    tv[9]  = '{0, 3'd2, 32'h0100_0000, 0, 2, 0, 32'hBEEF_5501, 0};
    tv[10] = '{1, 3'd1, 32'h0100_0001, 32'h5555_5555,
               1, 1, 32'h0, 0};
    tv[11] = '{0, 3'd2, 32'h0100_0002, 0, 1, 1, 32'h0, 0};
    tv[12] = '{0, 3'd2, 32'h00FF_FFFC, 0, 1, 1, 32'h0, 0};
    tv[13] = '{0, 3'd3, 32'h0100_0000, 0, 1, 1, 32'h0, 0};
    tv[14] = '{0, 3'd2, 32'h0100_0000, 0, 2, 0, 32'hBEEF_5501, 0};
    tv[15] = '{1, 3'd2, 32'h0100_0004, 32'h1122_3344,
               2, 0, 32'h0, 1};
    tv[16] = '{0, 3'd2, 32'h0100_0004, 0, 2, 0, 32'h1122_3344, 0};
    tv[17] = '{0, 3'd2, 32'h010F_FFFC, 0, 2, 0, 32'hDEAD_BEEF, 0};
    tv[18] = '{0, 3'd2, 32'h0110_0000, 0, 1, 1, 32'h0, 0};

    @(negedge clock);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.resp_err", 32'(resp_err), 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.rw", 32'(mem_read_write), 0);
    chk("rst.addr", mem_address, BASE);
    chk("rst.data_in", mem_data_in, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle.ready", 32'(req_ready), 1);

    preload(0, 32'h80FF_7F01);
    preload(1, 32'h0);
    for (int i = 0; i < 19; i++) begin
      run_req(tv[i].w, tv[i].f3, tv[i].a, tv[i].wd,
              first, nresp, err, rd, nwr);
      chk($sformatf("v%0d.lat", i), first, tv[i].lat);
      chk($sformatf("v%0d.nresp", i), nresp, 1);
      chk($sformatf("v%0d.err", i), 32'(err), 32'(tv[i].err));
      chk($sformatf("v%0d.rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d.writes", i), nwr, tv[i].nwr);
    end

    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int i = 0; i < 60; i++) begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e;
      int          n;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0)
        a = BASE - 32'($urandom_range(1, 8));
      else
        a = BASE + 32'($urandom_range(0, 255));
      e = mdl_err(w, f3, a);
      run_req(w, f3, a, wd, first, nresp, err, rd, nwr);
      chk($sformatf("r%0d.err", i), 32'(err), 32'(e));
      chk($sformatf("r%0d.nresp", i), nresp, 1);
      if (e) begin
        chk($sformatf("r%0d.lat", i), first, 1);
        chk($sformatf("r%0d.rdata", i), rd, 0);
        chk($sformatf("r%0d.writes", i), nwr, 0);
      end else if (!w) begin
        chk($sformatf("r%0d.lat", i), first, 2);
        chk($sformatf("r%0d.rdata", i), rd, mdl_load(f3, a));
        chk($sformatf("r%0d.writes", i), nwr, 0);
      end else begin
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++)
          ref_bytes[int'(a - BASE) + k] = wd[8*k +: 8];
        chk($sformatf("r%0d.lat", i), first, (n == 4) ? 2 : 3);
        chk($sformatf("r%0d.rdata", i), rd, 0);
        chk($sformatf("r%0d.writes", i), nwr, 1);
      end
    end
    for (int i = 0; i < 64; i++) begin
      run_req(0, 3'd2, BASE + 32'(i*4), 0,
              first, nresp, err, rd, nwr);
      chk($sformatf("rb%0d", i), rd,
          mdl_load(3'd2, BASE + 32'(i*4)));
    end

    // Back-to-back LW with req_valid held high
    preload(0, 32'h0BAD_CAFE);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
    req_addr = BASE; req_wdata = 0;
    rdy_pat = 0; rsp_pat = 0;
    for (int k = 0; k < 6; k++) begin
      rdy_pat[5-k] = req_ready;
      rsp_pat[5-k] = resp_valid;
      if (resp_valid)
        chk($sformatf("b2b.rdata%0d", k), resp_rdata,
            32'h0BAD_CAFE);
      if (k == 5) req_valid = 1'b0;
      @(posedge clock); @(negedge clock);
    end
    chk("b2b.ready_pat", 32'(rdy_pat), 32'b100100);
    chk("b2b.resp_pat", 32'(rsp_pat), 32'b001001);
    repeat (2) @(negedge clock);
    chk("b2b.idle_resp", 32'(resp_valid), 0);

    // Reset asserted while the store is in WRITE
    preload(8, 32'hCAFE_F00D);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = BASE + 32'h20; req_wdata = 32'h1234_5678;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    chk("rstw.in_write", 32'(mem_read_write), 1);
    w0 = wcount;
    reset = 1'b1;
    #1;
    chk("rstw.rw_drop", 32'(mem_read_write), 0);
    hits = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); @(negedge clock);
      if (resp_valid) hits++;
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (resp_valid) hits++;
      @(posedge clock); @(negedge clock);
    end
    chk("rstw.no_resp", hits, 0);
    chk("rstw.no_write", wcount - w0, 0);
    chk("rstw.ready", 32'(req_ready), 1);
    run_req(0, 3'd2, BASE + 32'h20, 0, first, nresp, err, rd, nwr);
    chk("rstw.lw", rd, 32'hCAFE_F00D);
    chk("rstw.lw_lat", first, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
